// File: rtl/alu_dm_feeder.sv
// rtl/alu_dm_feeder.sv - ALU16 write stage feeding the data-memory buffer
// Accepts operand pairs, strobes one result per write, and sequences drains/faults.
module alu_dm_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 11,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  input  logic              overset,
  output logic [DATA_W-1:0] din,
  output logic              DMWr,
  output logic              carry,
  output logic [CNT_W-1:0]  wr_count,
  output logic              full,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]        state;
  logic [CNT_W:0]    drain_cnt;
  logic [DATA_W-1:0] result;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [CNT_W:0]    drain_load;

  assign full       = (wr_count == CNT_W'(DEPTH));
  assign busy       = (state != IDLE);
  assign in_ready   = (state == IDLE) && !flush && !full;
  // One extra cycle beyond the stored entries acts as the wrap/clear cycle.
  assign drain_load = {1'b0, wr_count} + (CNT_W+1)'(1);

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    case (op)
      3'b000:  result = sum[DATA_W-1:0];
      3'b001:  result = diff[DATA_W-1:0];
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = a << b[3:0];
      3'b110:  result = a >> b[3:0];
      default: result = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      din       <= '0;
      DMWr      <= 1'b0;
      carry     <= 1'b0;
      wr_count  <= '0;
      err       <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (overset) begin
            state <= FAULT;
            err   <= 1'b1;
          end else if (flush) begin
            drain_cnt <= drain_load;
            state     <= DRAIN;
          end else if (in_valid && in_ready) begin
            din  <= result;
            DMWr <= 1'b1;
            if (op == 3'b000) carry <= sum[DATA_W];
            else if (op == 3'b001) carry <= diff[DATA_W];
            state <= WRITE;
          end
        end
        WRITE: begin
          DMWr <= 1'b0;
          if (!full) wr_count <= wr_count + CNT_W'(1);
          if (overset) begin
            state <= FAULT;
            err   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - (CNT_W+1)'(1);
          if (drain_cnt == (CNT_W+1)'(1)) begin
            wr_count <= '0;
            err      <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          if (flush) begin
            drain_cnt <= drain_load;
            state     <= DRAIN;
          end
        end
      endcase
    end
  end

endmodule
